// File: rtl/servo_360_giro_param.sv
// rtl/servo_360_giro_param.sv - 360 servo quarter-turn controller with built-in PWM (option: SERVO_HOLD_EN)
module servo_360_giro_param #(
   parameter int PWM_PERIOD = 1_000_000,
   parameter int PULSE_STOP = 75_000,
   parameter int PULSE_HOR  = 50_000,
   parameter int PULSE_ANTI = 100_000,
   parameter int T_QUARTO   = 25_000_000,
   parameter int T_ASSENTA  = 5_000_000,
   parameter int NQ_W       = 3
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            iniciar,
   input  logic            sentido,
   input  logic [NQ_W-1:0] quartos,
   input  logic            abortar,
   output logic            pwm,
   output logic            ocupado,
   output logic            pronto,
   output logic            erro,
   output logic [2:0]      db_estado
);

   localparam int CW    = $clog2(PWM_PERIOD);
   localparam int T_MAX = (T_QUARTO > T_ASSENTA) ? T_QUARTO : T_ASSENTA;
   localparam int TW    = $clog2(T_MAX);

   localparam logic [2:0] INICIAL    = 3'b000;
   localparam logic [2:0] PREPARACAO = 3'b001;
   localparam logic [2:0] GIRANDO    = 3'b010;
   localparam logic [2:0] ASSENTANDO = 3'b011;
   localparam logic [2:0] FIM        = 3'b100;

   localparam logic [CW-1:0]   CNT_LAST = CW'(PWM_PERIOD - 1);
   localparam logic [CW-1:0]   W_STOP   = CW'(PULSE_STOP);
   localparam logic [CW-1:0]   W_HOR    = CW'(PULSE_HOR);
   localparam logic [CW-1:0]   W_ANTI   = CW'(PULSE_ANTI);
   localparam logic [TW-1:0]   TQ_LAST  = TW'(T_QUARTO - 1);
   localparam logic [TW-1:0]   TA_LAST  = TW'(T_ASSENTA - 1);
   localparam logic [NQ_W-1:0] UM       = NQ_W'(1);

   logic [2:0]      estado;
   logic [TW-1:0]   timer;
   logic [NQ_W-1:0] restantes;
   logic [NQ_W-1:0] quartos_l;
   logic            sentido_l;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   width_l;
   logic [CW-1:0]   width_alvo;
   logic            en_l;
   logic            en_alvo;

   // Move sequencing: start latch, quarter-turn timing, settle, abort and sticky error
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado    <= INICIAL;
         timer     <= '0;
         restantes <= '0;
         quartos_l <= '0;
         sentido_l <= 1'b0;
         erro      <= 1'b0;
      end else begin
         case (estado)
            INICIAL: begin
               if (iniciar) begin
                  sentido_l <= sentido;
                  quartos_l <= quartos;
                  erro      <= 1'b0;
                  estado    <= (quartos != '0) ? PREPARACAO : FIM;
               end
            end
            PREPARACAO: begin
               timer <= '0;
               if (abortar) begin
                  erro   <= 1'b1;
                  estado <= ASSENTANDO;
               end else begin
                  restantes <= quartos_l;
                  estado    <= GIRANDO;
               end
            end
            GIRANDO: begin
               if (abortar) begin
                  erro   <= 1'b1;
                  timer  <= '0;
                  estado <= ASSENTANDO;
               end else if (timer == TQ_LAST) begin
                  timer <= '0;
                  if (restantes != '0)
                     restantes <= restantes - UM;
                  // Treat an (unreachable) zero count like the last quarter so the move always ends
                  if (restantes <= UM)
                     estado <= ASSENTANDO;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            ASSENTANDO: begin
               if (timer == TA_LAST) begin
                  timer  <= '0;
                  estado <= FIM;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            FIM: begin
               estado <= INICIAL;
            end
            default: begin
               timer  <= '0;
               estado <= INICIAL;
            end
         endcase
      end
   end

   // Debug state code; anything outside the known set reads back as 111
   always_comb begin
      db_estado = 3'b111;
      case (estado)
         INICIAL, PREPARACAO, GIRANDO, ASSENTANDO, FIM: db_estado = estado;
         default: db_estado = 3'b111;
      endcase
   end

   assign ocupado = (estado != INICIAL);
   assign pronto  = (estado == FIM);

   // Pulse width the servo should receive in the current state
   always_comb begin
      width_alvo = W_STOP;
      if (estado == GIRANDO)
         width_alvo = sentido_l ? W_ANTI : W_HOR;
   end

`ifdef SERVO_HOLD_EN
   assign en_alvo = 1'b1;
`else
   assign en_alvo = (estado != INICIAL);
`endif

   // Free-running frame counter; width and enable only change at frame boundaries
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         width_l <= W_STOP;
         en_l    <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         cnt     <= '0;
         width_l <= width_alvo;
         en_l    <= en_alvo;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign pwm = (cnt < width_l) & en_l;

endmodule

// File: tb/tb_servo_360_giro_param.sv
// tb/tb_servo_360_giro_param.sv - randomized directed bench with schedule-based reference model
module tb_servo_360_giro_param;

   localparam int PP = 20, PS = 3, PH = 2, PA = 4, TQ = 100, TA = 40, NQ = 3;
   localparam int MAXC = 8000;
   localparam int S_INI = 0, S_PREP = 1, S_GIR = 2, S_ASS = 3, S_FIM = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          iniciar = 1'b0;
   logic          sentido = 1'b0;
   logic [NQ-1:0] quartos = '0;
   logic          abortar = 1'b0;
   logic          pwm, ocupado, pronto, erro;
   logic [2:0]    db_estado;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int run_len = 0;

   // Expected state/latched direction/erro after each clock edge since reset release
   int exp_st  [MAXC];
   bit exp_dir [MAXC];
   bit exp_err [MAXC];

   servo_360_giro_param #(
      .PWM_PERIOD(PP), .PULSE_STOP(PS), .PULSE_HOR(PH), .PULSE_ANTI(PA),
      .T_QUARTO(TQ), .T_ASSENTA(TA), .NQ_W(NQ)
   ) dut (
      .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .sentido(sentido),
      .quartos(quartos), .abortar(abortar), .pwm(pwm), .ocupado(ocupado),
      .pronto(pronto), .erro(erro), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < MAXC; i++) begin
         exp_st[i] = S_INI; exp_dir[i] = 1'b0; exp_err[i] = 1'b0;
      end
      cyc = 0;
      run_len = 0;
   endtask

   task automatic fill_idle(input int from);
      for (int i = from; i < MAXC; i++) exp_st[i] = S_INI;
   endtask

   // A start accepted at edge k: PREP, q*TQ cycles turning, TA settling, one FIM
   task automatic schedule_start(input int k, input int q, input bit dir);
      for (int i = k; i < MAXC; i++) begin exp_err[i] = 1'b0; exp_dir[i] = dir; end
      if (q == 0) begin
         exp_st[k] = S_FIM;
         fill_idle(k + 1);
      end else begin
         exp_st[k] = S_PREP;
         for (int i = 1; i <= q * TQ; i++) exp_st[k + i] = S_GIR;
         for (int i = 1; i <= TA; i++) exp_st[k + q * TQ + i] = S_ASS;
         exp_st[k + q * TQ + TA + 1] = S_FIM;
         fill_idle(k + q * TQ + TA + 2);
      end
   endtask

   // An abort taken at edge k: TA cycles settling then FIM, erro set
   task automatic schedule_abort(input int k);
      for (int i = k; i < MAXC; i++) exp_err[i] = 1'b1;
      for (int i = 0; i < TA; i++) exp_st[k + i] = S_ASS;
      exp_st[k + TA] = S_FIM;
      fill_idle(k + TA + 1);
   endtask

   // pwm after edge k: frame position k%PP, frame content chosen by the state just before the frame began
   function automatic bit exp_pwm(input int k);
      int c, k0, w, s;
      bit en;
      c  = k % PP;
      k0 = k - c;
      if (k0 == 0) begin
         w = PS; en = 1'b0;
      end else begin
         s = exp_st[k0 - 1];
         w = (s == S_GIR) ? (exp_dir[k0 - 1] ? PA : PH) : PS;
`ifdef SERVO_HOLD_EN
         en = 1'b1;
`else
         en = (s != S_INI);
`endif
      end
      return (c < w) && en;
   endfunction

   task automatic step();
      @(posedge clock);
      cyc++;
      #1;
      chk("db_estado", db_estado, exp_st[cyc]);
      chk("ocupado", ocupado, exp_st[cyc] != S_INI);
      chk("pronto", pronto, exp_st[cyc] == S_FIM);
      chk("erro", erro, exp_err[cyc]);
      chk("pwm", pwm, exp_pwm(cyc));
      if (pwm === 1'b1) run_len++;
      else begin
         if (run_len > 0) begin
            checks++;
            assert (run_len == PH || run_len == PS || run_len == PA) else begin
               errors++;
               $error("FAIL pulse_width at cycle %0d: observed %0d expected 2, 3 or 4", cyc, run_len);
            end
         end
         run_len = 0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_st[cyc] != S_INI && n < 2000) begin step(); n++; end
      if (exp_st[cyc] != S_INI) begin
         checks++; errors++;
         $error("FAIL wait_idle: observed busy expected idle within 2000 cycles");
      end
   endtask

   task automatic start_move(input int q, input bit dir, input bit abt);
      wait_idle();
      iniciar = 1'b1; sentido = dir; quartos = NQ'(q); abortar = abt;
      schedule_start(cyc + 1, q, dir);
      step();
      iniciar = 1'b0; abortar = 1'b0;
   endtask

   task automatic abort_now();
      if (exp_st[cyc] == S_PREP || exp_st[cyc] == S_GIR) begin
         abortar = 1'b1;
         schedule_abort(cyc + 1);
         step();
         abortar = 1'b0;
      end
   endtask

   initial begin
      int q, n;
      bit d;
      model_reset();
      #12;
      chk("reset_pwm", pwm, 1'b0);
      chk("reset_estado", db_estado, 3'b000);
      chk("reset_ocupado", ocupado, 1'b0);
      chk("reset_pronto", pronto, 1'b0);
      chk("reset_erro", erro, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      repeat (50) step();

      // zero quarters: straight to FIM
      start_move(0, 1'b0, 1'b0);
      repeat (45) step();
      // two clockwise quarters, then one counter-clockwise
      start_move(2, 1'b0, 1'b0);
      wait_idle();
      repeat (7) step();
      start_move(1, 1'b1, 1'b0);
      wait_idle();

      // abort 30 cycles into GIRANDO, abort ignored while settling, next start clears erro
      start_move(3, 1'b0, 1'b0);
      repeat (31) step();
      abort_now();
      repeat (5) step();
      abortar = 1'b1;
      repeat (3) step();
      abortar = 1'b0;
      wait_idle();
      repeat (30) step();
      start_move(1, 1'b1, 1'b0);
      wait_idle();

      // input toggling during GIRANDO
      start_move(2, 1'b0, 1'b0);
      repeat (5) step();
      for (int i = 0; i < 150; i++) begin
         iniciar = 1'($urandom); sentido = 1'($urandom); quartos = NQ'($urandom);
         step();
      end
      iniciar = 1'b0; sentido = 1'b0; quartos = '0;
      wait_idle();

      // randomized moves with random aborts and random idle gaps
      for (int m = 0; m < 8; m++) begin
         q = $urandom_range(0, 3);
         d = 1'($urandom);
         repeat ($urandom_range(0, 25)) step();
         start_move(q, d, ($urandom % 4) == 0);
         if (q != 0 && ($urandom % 3) == 0) begin
            n = $urandom_range(0, q * TQ);
            repeat (n) step();
            abort_now();
         end
         wait_idle();
      end

      // asynchronous reset mid-GIRANDO while the pulse is high
      start_move(3, 1'($urandom), 1'b0);
      n = 0;
      while (!(exp_st[cyc] == S_GIR && exp_pwm(cyc) && cyc > 60) && n < 400) begin step(); n++; end
      chk("pre_reset_pwm", pwm, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset_pwm", pwm, 1'b0);
      chk("async_reset_estado", db_estado, 3'b000);
      chk("async_reset_ocupado", ocupado, 1'b0);
      chk("async_reset_erro", erro, 1'b0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      repeat (60) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
